// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: ALU opcodes, forward
// select encoding and the registered control bundle.
package id_ex_stage_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1011;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [3:0] alu_control;
  } ctrl_t;

  // A bubble is the all-zero bundle: ALU_AND with every write-enable low.
  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic ctrl_t gate_ctrl(input ctrl_t c);
    return c.valid ? c : CTRL_BUBBLE;
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux for one source register: EX/MEM beats MEM/WB beats
// the register-file value; register 0 never matches.
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [DATA_W-1:0] reg_data,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              ex_mem_reg_write,
  input  logic [DATA_W-1:0] ex_mem_result,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic              mem_wb_reg_write,
  input  logic [DATA_W-1:0] mem_wb_data,
  output logic [DATA_W-1:0] data
);

  logic     ex_hit;
  logic     wb_hit;
  fwd_sel_e sel;

  assign ex_hit = ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == rs);
  assign wb_hit = mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == rs);

  always_comb begin
    sel = FWD_REG;
    if (ex_hit) begin
      sel = FWD_EXMEM;
    end else if (wb_hit) begin
      sel = FWD_MEMWB;
    end
  end

  always_comb begin
    data = reg_data;
    case (sel)
      FWD_EXMEM: data = ex_mem_result;
      FWD_MEMWB: data = mem_wb_data;
      default:   data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use stall detection; feeds A, B and the ALU code to the ALU.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Valid_In,
  input  logic [REG_AW-1:0] Rs1_In,
  input  logic [REG_AW-1:0] Rs2_In,
  input  logic [REG_AW-1:0] Rd_In,
  input  logic [DATA_W-1:0] Rs1Data_In,
  input  logic [DATA_W-1:0] Rs2Data_In,
  input  logic [DATA_W-1:0] Imm_In,
  input  logic              ALUSrc_In,
  input  logic [3:0]        ALUcontrol_In,
  input  logic              RegWrite_In,
  input  logic              MemRead_In,
  input  logic              MemWrite_In,
  input  logic              MemtoReg_In,
  input  logic              Flush_In,
  input  logic              Hold_In,
  input  logic [REG_AW-1:0] ExMemRd_In,
  input  logic              ExMemRegWrite_In,
  input  logic [DATA_W-1:0] ExMemResult_In,
  input  logic [REG_AW-1:0] MemWbRd_In,
  input  logic              MemWbRegWrite_In,
  input  logic [DATA_W-1:0] MemWbData_In,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] StoreData,
  output logic [3:0]        ALUcontrol_Out,
  output logic [REG_AW-1:0] Rd_Out,
  output logic              Valid_Out,
  output logic              RegWrite_Out,
  output logic              MemRead_Out,
  output logic              MemWrite_Out,
  output logic              MemtoReg_Out,
  output logic              Stall_Out
);

  ctrl_t             ctrl_in;
  ctrl_t             ctrl_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] rs1_data_q;
  logic [DATA_W-1:0] rs2_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] rs1_fwd;
  logic [DATA_W-1:0] rs2_fwd;
  logic              load_use;

  assign ctrl_in = '{
    valid:       Valid_In,
    reg_write:   RegWrite_In,
    mem_read:    MemRead_In,
    mem_write:   MemWrite_In,
    mem_to_reg:  MemtoReg_In,
    alu_src:     ALUSrc_In,
    alu_control: ALUcontrol_In
  };

  // Rs2 is compared even for immediate-form decodes; a spare stall is harmless.
  assign load_use = ctrl_q.valid && ctrl_q.mem_read && (rd_q != '0) && Valid_In &&
                    ((rd_q == Rs1_In) || (rd_q == Rs2_In));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= CTRL_BUBBLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else if (!Hold_In) begin
      if (Flush_In || load_use) begin
        ctrl_q     <= CTRL_BUBBLE;
        rs1_q      <= '0;
        rs2_q      <= '0;
        rd_q       <= '0;
        rs1_data_q <= '0;
        rs2_data_q <= '0;
        imm_q      <= '0;
      end else begin
        ctrl_q     <= gate_ctrl(ctrl_in);
        rs1_q      <= Rs1_In;
        rs2_q      <= Rs2_In;
        rd_q       <= Rd_In;
        rs1_data_q <= Rs1Data_In;
        rs2_data_q <= Rs2Data_In;
        imm_q      <= Imm_In;
      end
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs               (rs1_q),
    .reg_data         (rs1_data_q),
    .ex_mem_rd        (ExMemRd_In),
    .ex_mem_reg_write (ExMemRegWrite_In),
    .ex_mem_result    (ExMemResult_In),
    .mem_wb_rd        (MemWbRd_In),
    .mem_wb_reg_write (MemWbRegWrite_In),
    .mem_wb_data      (MemWbData_In),
    .data             (rs1_fwd)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs               (rs2_q),
    .reg_data         (rs2_data_q),
    .ex_mem_rd        (ExMemRd_In),
    .ex_mem_reg_write (ExMemRegWrite_In),
    .ex_mem_result    (ExMemResult_In),
    .mem_wb_rd        (MemWbRd_In),
    .mem_wb_reg_write (MemWbRegWrite_In),
    .mem_wb_data      (MemWbData_In),
    .data             (rs2_fwd)
  );

  assign A              = rs1_fwd;
  assign B              = ctrl_q.alu_src ? imm_q : rs2_fwd;
  assign StoreData      = rs2_fwd;
  assign ALUcontrol_Out = ctrl_q.alu_control;
  assign Rd_Out         = rd_q;
  assign Valid_Out      = ctrl_q.valid;
  assign RegWrite_Out   = ctrl_q.reg_write;
  assign MemRead_Out    = ctrl_q.mem_read;
  assign MemWrite_Out   = ctrl_q.mem_write;
  assign MemtoReg_Out   = ctrl_q.mem_to_reg;
  assign Stall_Out      = load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage: capture, forwarding priority,
// load-use stall, flush, hold and asynchronous reset.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int NV     = 20;

  typedef struct {
    logic [31:0] valid, rs1, rs2, rd, d1, d2, imm, asrc, aluc, rw, mr, mw, m2r;
    logic [31:0] flush, hold, exrd, exrw, exres, wbrd, wbrw, wbdata;
  } vin_t;

  typedef struct {
    logic [31:0] stall, a, b, sd, aluc, rd, valid, rw, mr, mw, m2r;
  } vexp_t;

  logic              clk;
  logic              rst_n;
  logic              Valid_In;
  logic [REG_AW-1:0] Rs1_In, Rs2_In, Rd_In;
  logic [DATA_W-1:0] Rs1Data_In, Rs2Data_In, Imm_In;
  logic              ALUSrc_In;
  logic [3:0]        ALUcontrol_In;
  logic              RegWrite_In, MemRead_In, MemWrite_In, MemtoReg_In;
  logic              Flush_In, Hold_In;
  logic [REG_AW-1:0] ExMemRd_In, MemWbRd_In;
  logic              ExMemRegWrite_In, MemWbRegWrite_In;
  logic [DATA_W-1:0] ExMemResult_In, MemWbData_In;
  logic [DATA_W-1:0] A, B, StoreData;
  logic [3:0]        ALUcontrol_Out;
  logic [REG_AW-1:0] Rd_Out;
  logic              Valid_Out, RegWrite_Out, MemRead_Out, MemWrite_Out, MemtoReg_Out;
  logic              Stall_Out;

  int n_checks = 0;
  int n_pass   = 0;

  vin_t  vi [NV];
  vexp_t ve [NV];

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .Valid_In         (Valid_In),
    .Rs1_In           (Rs1_In),
    .Rs2_In           (Rs2_In),
    .Rd_In            (Rd_In),
    .Rs1Data_In       (Rs1Data_In),
    .Rs2Data_In       (Rs2Data_In),
    .Imm_In           (Imm_In),
    .ALUSrc_In        (ALUSrc_In),
    .ALUcontrol_In    (ALUcontrol_In),
    .RegWrite_In      (RegWrite_In),
    .MemRead_In       (MemRead_In),
    .MemWrite_In      (MemWrite_In),
    .MemtoReg_In      (MemtoReg_In),
    .Flush_In         (Flush_In),
    .Hold_In          (Hold_In),
    .ExMemRd_In       (ExMemRd_In),
    .ExMemRegWrite_In (ExMemRegWrite_In),
    .ExMemResult_In   (ExMemResult_In),
    .MemWbRd_In       (MemWbRd_In),
    .MemWbRegWrite_In (MemWbRegWrite_In),
    .MemWbData_In     (MemWbData_In),
    .A                (A),
    .B                (B),
    .StoreData        (StoreData),
    .ALUcontrol_Out   (ALUcontrol_Out),
    .Rd_Out           (Rd_Out),
    .Valid_Out        (Valid_Out),
    .RegWrite_Out     (RegWrite_Out),
    .MemRead_Out      (MemRead_Out),
    .MemWrite_Out     (MemWrite_Out),
    .MemtoReg_Out     (MemtoReg_Out),
    .Stall_Out        (Stall_Out)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL v%0d %s: got 0x%0h expected 0x%0h", idx, nm, act, exp);
  endtask

  task automatic drive(input vin_t v);
    Valid_In         = v.valid[0];
    Rs1_In           = v.rs1[REG_AW-1:0];
    Rs2_In           = v.rs2[REG_AW-1:0];
    Rd_In            = v.rd[REG_AW-1:0];
    Rs1Data_In       = v.d1;
    Rs2Data_In       = v.d2;
    Imm_In           = v.imm;
    ALUSrc_In        = v.asrc[0];
    ALUcontrol_In    = v.aluc[3:0];
    RegWrite_In      = v.rw[0];
    MemRead_In       = v.mr[0];
    MemWrite_In      = v.mw[0];
    MemtoReg_In      = v.m2r[0];
    Flush_In         = v.flush[0];
    Hold_In          = v.hold[0];
    ExMemRd_In       = v.exrd[REG_AW-1:0];
    ExMemRegWrite_In = v.exrw[0];
    ExMemResult_In   = v.exres;
    MemWbRd_In       = v.wbrd[REG_AW-1:0];
    MemWbRegWrite_In = v.wbrw[0];
    MemWbData_In     = v.wbdata;
  endtask

  task automatic chk_outs(input int idx, input vexp_t e);
    chk("A", idx, A, e.a);
    chk("B", idx, B, e.b);
    chk("StoreData", idx, StoreData, e.sd);
    chk("ALUcontrol_Out", idx, 32'(ALUcontrol_Out), e.aluc);
    chk("Rd_Out", idx, 32'(Rd_Out), e.rd);
    chk("Valid_Out", idx, 32'(Valid_Out), e.valid);
    chk("RegWrite_Out", idx, 32'(RegWrite_Out), e.rw);
    chk("MemRead_Out", idx, 32'(MemRead_Out), e.mr);
    chk("MemWrite_Out", idx, 32'(MemWrite_Out), e.mw);
    chk("MemtoReg_Out", idx, 32'(MemtoReg_Out), e.m2r);
  endtask

  initial begin
    vexp_t zero_e;
    vin_t  tmp;
    // order: valid rs1 rs2 rd d1 d2 imm asrc aluc rw mr mw m2r flush hold exrd exrw exres wbrd wbrw wbdata
    vi[0]  = '{1, 1, 2, 5, 'h5, 'h7, 0, 0, 'b0010, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vi[1]  = '{1, 3, 0, 6, 'h10, 'h20, 'h100, 1, 'b0001, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vi[2]  = '{1, 3, 9, 7, 'h11, 'h22, 0, 0, 'b0110, 1, 0, 0, 0, 0, 0, 3, 1, 'hAA, 3, 1, 'hBB};
    vi[3]  = '{1, 3, 9, 7, 'h11, 'h22, 0, 0, 'b0110, 1, 0, 0, 0, 0, 0, 3, 0, 'hAA, 3, 1, 'hBB};
    vi[4]  = '{1, 0, 9, 7, 'h33, 'h22, 0, 0, 'b0110, 1, 0, 0, 0, 0, 0, 0, 1, 'hAA, 0, 1, 'hBB};
    vi[5]  = '{1, 1, 2, 3, 'h1, 'h2, 'h4, 1, 'b0000, 1, 0, 0, 0, 0, 0, 2, 1, 'hC0, 1, 1, 'hD0};
    vi[6]  = '{0, 1, 2, 8, 'h1, 'h2, 0, 0, 'b0010, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vi[7]  = '{1, 1, 0, 4, 'h100, 0, 'h8, 1, 'b0010, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vi[8]  = '{1, 5, 4, 9, 'h50, 'h40, 0, 0, 'b0010, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vi[9]  = '{1, 5, 4, 9, 'h50, 'h40, 0, 0, 'b0010, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 'h77};
    vi[10] = '{1, 1, 2, 3, 'h1, 'h2, 0, 0, 'b0010, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vi[11] = '{1, 0, 0, 6, 'h200, 0, 'h4, 1, 'b0010, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vi[12] = '{1, 6, 1, 7, 'h1, 'h2, 0, 0, 'b0010, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vi[13] = '{1, 2, 3, 8, 'h12, 'h13, 0, 0, 'b1000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vi[14] = '{1, 1, 1, 9, 'hFF, 'hEE, 0, 0, 'b0001, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vi[15] = '{1, 1, 1, 9, 'hFF, 'hEE, 0, 0, 'b0001, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    vi[16] = '{1, 1, 1, 9, 'hFF, 'hEE, 0, 0, 'b0001, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vi[17] = '{1, 0, 0, 10, 0, 0, 0, 1, 'b0010, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vi[18] = '{1, 10, 0, 11, 'h5, 'h6, 0, 0, 'b0010, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vi[19] = '{1, 10, 0, 11, 'h5, 'h6, 0, 0, 'b0010, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    // order: stall a b sd aluc rd valid rw mr mw m2r
    ve[0]  = '{0, 'h5, 'h7, 'h7, 'b0010, 5, 1, 1, 0, 0, 0};
    ve[1]  = '{0, 'h10, 'h100, 'h20, 'b0001, 6, 1, 1, 0, 0, 0};
    ve[2]  = '{0, 'hAA, 'h22, 'h22, 'b0110, 7, 1, 1, 0, 0, 0};
    ve[3]  = '{0, 'hBB, 'h22, 'h22, 'b0110, 7, 1, 1, 0, 0, 0};
    ve[4]  = '{0, 'h33, 'h22, 'h22, 'b0110, 7, 1, 1, 0, 0, 0};
    ve[5]  = '{0, 'hD0, 'h4, 'hC0, 'b0000, 3, 1, 1, 0, 0, 0};
    ve[6]  = '{0, 'h1, 'h2, 'h2, 'b0000, 8, 0, 0, 0, 0, 0};
    ve[7]  = '{0, 'h100, 'h8, 0, 'b0010, 4, 1, 1, 1, 0, 1};
    ve[8]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    ve[9]  = '{0, 'h50, 'h77, 'h77, 'b0010, 9, 1, 1, 0, 0, 0};
    ve[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    ve[11] = '{0, 'h200, 'h4, 0, 'b0010, 6, 1, 1, 1, 0, 1};
    ve[12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    ve[13] = '{0, 'h12, 'h13, 'h13, 'b1000, 8, 1, 1, 0, 0, 0};
    ve[14] = '{0, 'h12, 'h13, 'h13, 'b1000, 8, 1, 1, 0, 0, 0};
    ve[15] = '{0, 'h12, 'h13, 'h13, 'b1000, 8, 1, 1, 0, 0, 0};
    ve[16] = '{0, 'h12, 'h13, 'h13, 'b1000, 8, 1, 1, 0, 0, 0};
    ve[17] = '{0, 0, 0, 0, 'b0010, 10, 1, 1, 1, 0, 1};
    ve[18] = '{1, 0, 0, 0, 'b0010, 10, 1, 1, 1, 0, 1};
    ve[19] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    zero_e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    // Reset with a live decode slot on the inputs
    rst_n = 1'b0;
    tmp = vi[0];
    drive(tmp);
    #2;
    chk_outs(100, zero_e);
    chk("Stall_Out", 100, 32'(Stall_Out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors: Stall_Out checked before the edge, registers after
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vi[i]);
      #1;
      chk("Stall_Out", i, 32'(Stall_Out), ve[i].stall);
      @(posedge clk);
      #1;
      chk_outs(i, ve[i]);
    end

    // Asynchronous reset mid-stream with a load-use stall, hold and flush pending
    @(negedge clk);
    tmp = '{1, 0, 0, 4, 'h9, 0, 'h4, 1, 'b0010, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    drive(tmp);
    @(posedge clk);
    #1;
    chk("Rd_Out", 200, 32'(Rd_Out), 4);
    chk("MemRead_Out", 200, 32'(MemRead_Out), 1);
    @(negedge clk);
    tmp = '{1, 4, 0, 7, 'h1, 'h2, 0, 0, 'b1011, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    drive(tmp);
    #1;
    chk("Stall_Out", 201, 32'(Stall_Out), 1);
    rst_n = 1'b0;
    #1;
    chk_outs(202, zero_e);
    chk("Stall_Out", 202, 32'(Stall_Out), 0);
    @(posedge clk);
    #1;
    chk("Valid_Out", 203, 32'(Valid_Out), 0);
    chk("A", 203, A, 0);
    rst_n = 1'b1;

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
